// File: rtl/pc_unit.sv
// Program-counter unit: selects the next instruction address from sequential, branch,
// jump, call or return-address-stack sources, with stall and sticky error flags.
module pc_unit #(
   parameter int WIDTH      = 8,
   parameter int STEP       = 1,
   parameter int RESET_ADDR = 0,
   parameter int RAS_DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic                           branch_taken,
   input  logic [WIDTH-1:0]               branch_target,
   input  logic                           jump,
   input  logic                           call,
   input  logic                           ret,
   input  logic [WIDTH-1:0]               jump_target,
   output logic [WIDTH-1:0]               out,
   output logic [WIDTH-1:0]               pc_plus,
   output logic [$clog2(RAS_DEPTH):0]     ras_count,
   output logic                           ras_empty,
   output logic                           ras_full,
   output logic                           ovf,
   output logic                           unf,
   output logic                           cmd_err
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   // Power-up value comes from the declaration, so the PC is defined before the first reset.
   logic [WIDTH-1:0] pc_q = WIDTH'(RESET_ADDR);
   logic [PW-1:0]    top_q;
   logic [CW-1:0]    count_q;
   logic             ovf_q;
   logic             unf_q;
   logic             err_q;
   logic [WIDTH-1:0] ras [RAS_DEPTH];

   logic             illegal;
   logic             do_push;
   logic [PW-1:0]    top_inc;

   assign pc_plus   = pc_q + WIDTH'(STEP);
   assign out       = pc_q;
   assign ras_count = count_q;
   assign ras_empty = (count_q == '0);
   assign ras_full  = (count_q == CW'(RAS_DEPTH));
   assign ovf       = ovf_q;
   assign unf       = unf_q;
   assign cmd_err   = err_q;

   // top_q points at the most recent entry; the slot after it is where a push lands,
   // which is also the oldest entry once the stack is full.
   assign top_inc = top_q + PW'(1);

   always_comb begin
      illegal = (ret & call) | (ret & jump) | (call & jump);
      do_push = ~rst & ~stall & ~illegal & ~ret & call;
   end

   // NOTE: the stack array has no reset; entries beyond count are never read, so
   // clearing the count is enough and keeps the array free to map onto plain storage.
   always_ff @(negedge clk) begin
      if (do_push)
         ras[top_inc] <= pc_plus;
   end

   // NOTE: all state uses non-blocking assignments so every branch sees the
   // pre-edge values of pc_q, top_q and count_q.
   always_ff @(negedge clk) begin
      if (rst) begin
         pc_q    <= WIDTH'(RESET_ADDR);
         top_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (!stall) begin
         if (illegal) begin
            err_q <= 1'b1;
            pc_q  <= pc_plus;
         end else if (ret) begin
            if (count_q != '0) begin
               pc_q    <= ras[top_q];
               top_q   <= top_q - PW'(1);
               count_q <= count_q - CW'(1);
            end else begin
               pc_q  <= pc_plus;
               unf_q <= 1'b1;
            end
         end else if (call) begin
            pc_q  <= jump_target;
            top_q <= top_inc;
            if (ras_full)
               ovf_q <= 1'b1;
            else
               count_q <= count_q + CW'(1);
         end else if (jump) begin
            pc_q <= jump_target;
         end else if (branch_taken) begin
            pc_q <= branch_target;
         end else begin
            pc_q <= pc_plus;
         end
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential, wrap, stall, priority, nested calls,
// stack overflow/underflow, illegal commands and reset discarding the stack.
module tb_pc_unit;

   logic       clk = 1'b1;
   logic       rst = 1'b0;
   logic       stall = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_target = '0;
   logic       jump = 1'b0;
   logic       call = 1'b0;
   logic       ret = 1'b0;
   logic [7:0] jump_target = '0;
   logic [7:0] out;
   logic [7:0] pc_plus;
   logic [2:0] ras_count;
   logic       ras_empty;
   logic       ras_full;
   logic       ovf;
   logic       unf;
   logic       cmd_err;

   int checks = 0;
   int failures = 0;

   pc_unit #(
      .WIDTH(8), .STEP(1), .RESET_ADDR(8'h10), .RAS_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
      .out(out), .pc_plus(pc_plus), .ras_count(ras_count),
      .ras_empty(ras_empty), .ras_full(ras_full),
      .ovf(ovf), .unf(unf), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one falling edge and sample just after it.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
   endtask

   task automatic flags(input string tag, input logic [2:0] exp);
      check(tag, {29'd0, ovf, unf, cmd_err}, {29'd0, exp});
   endtask

   initial begin
      #1;
      check("powerup_out", out, 8'h10);

      // Reset then sequential
      rst = 1; step(); rst = 0;
      check("rst_out", out, 8'h10);
      check("rst_count", ras_count, 3'd0);
      check("rst_empty", ras_empty, 1'b1);
      flags("rst_flags", 3'b000);
      step(); check("seq1", out, 8'h11);
      step(); check("seq2", out, 8'h12);
      step(); check("seq3", out, 8'h13);
      flags("seq_flags", 3'b000);

      // Wrap and stall
      jump = 1; jump_target = 8'hFF; step(); idle();
      check("jump_ff", out, 8'hFF);
      check("pc_plus_wrap", pc_plus, 8'h00);
      step(); check("wrap", out, 8'h00);
      stall = 1; branch_taken = 1; branch_target = 8'h77;
      step(); step();
      check("stall_out", out, 8'h00);
      check("stall_pc_plus", pc_plus, 8'h01);
      idle();

      // Priority
      jump = 1; jump_target = 8'h40; branch_taken = 1; branch_target = 8'h80;
      step(); check("jump_over_branch", out, 8'h40);
      jump = 0; step(); check("branch", out, 8'h80);
      idle();

      // Nested call/ret
      jump = 1; jump_target = 8'h05; step(); idle();
      check("at05", out, 8'h05);
      call = 1; jump_target = 8'h20; step();
      check("call1_out", out, 8'h20); check("call1_cnt", ras_count, 3'd1);
      jump_target = 8'h30; step();
      check("call2_out", out, 8'h30); check("call2_cnt", ras_count, 3'd2);
      stall = 1; step();
      check("stall_call_out", out, 8'h30); check("stall_call_cnt", ras_count, 3'd2);
      idle(); ret = 1; step();
      check("ret1_out", out, 8'h21); check("ret1_cnt", ras_count, 3'd1);
      step();
      check("ret2_out", out, 8'h06); check("ret2_cnt", ras_count, 3'd0);
      check("ret2_empty", ras_empty, 1'b1);
      flags("nest_flags", 3'b000);
      idle();

      // Overflow: pushes 07, 51, 61, 71, then 81 overwrites 07
      call = 1;
      jump_target = 8'h50; step();
      jump_target = 8'h60; step();
      jump_target = 8'h70; step();
      jump_target = 8'h80; step();
      check("full4_cnt", ras_count, 3'd4);
      check("full4_full", ras_full, 1'b1);
      check("full4_ovf", ovf, 1'b0);
      jump_target = 8'h90; step();
      check("call5_out", out, 8'h90);
      check("call5_cnt", ras_count, 3'd4);
      check("call5_ovf", ovf, 1'b1);
      idle(); ret = 1;
      step(); check("pop1", out, 8'h81); check("pop1_cnt", ras_count, 3'd3);
      step(); check("pop2", out, 8'h71);
      step(); check("pop3", out, 8'h61);
      step(); check("pop4", out, 8'h51); check("pop4_cnt", ras_count, 3'd0);
      check("pop4_unf", unf, 1'b0);
      step(); check("pop5_out", out, 8'h52); check("pop5_cnt", ras_count, 3'd0);
      flags("pop5_flags", 3'b110);
      idle();

      // Illegal call+ret leaves stack alone
      call = 1; jump_target = 8'h08; step();
      check("at08", out, 8'h08); check("at08_cnt", ras_count, 3'd1);
      ret = 1; jump_target = 8'h33; step();
      check("illegal_out", out, 8'h09);
      check("illegal_cnt", ras_count, 3'd1);
      check("illegal_err", cmd_err, 1'b1);
      idle(); ret = 1; step();
      check("after_illegal_ret", out, 8'h53);
      idle(); jump = 1; branch_taken = 1; branch_target = 8'h99; jump_target = 8'h0A; step();
      check("jump_branch_legal", out, 8'h0A);
      idle();

      // Reset mid-sequence discards the stack and clears flags
      call = 1; jump_target = 8'h44; step();
      check("pre_rst_cnt", ras_count, 3'd1);
      rst = 1; step();
      check("rst2_out", out, 8'h10);
      check("rst2_cnt", ras_count, 3'd0);
      flags("rst2_flags", 3'b000);
      idle(); ret = 1; step();
      check("ret_after_rst", out, 8'h11);
      check("ret_after_rst_unf", unf, 1'b1);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
